// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle signed adder, DIGIT bits per clock, start/busy/done handshake
module serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             Cout,
  output logic             overflow
);

  localparam int N    = WIDTH / DIGIT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_next;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dig_sum;
  logic             accept;
  logic             last;
  logic             msb_carry;
  int               base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Start is only honoured outside RUN; requests while busy are dropped silently.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last       = (idx == IDX_LAST);
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One digit of the ripple: slice out, add with carry, splice the result back in.
  always_comb begin
    base      = int'(idx) * DIGIT;
    a_dig     = a_q[base +: DIGIT];
    b_dig     = b_q[base +: DIGIT];
    dig_sum   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    psum_next = psum;
    psum_next[base +: DIGIT] = dig_sum[DIGIT-1:0];
    // Carry into the top bit of this digit, recovered from the sum bit.
    msb_carry = dig_sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      psum     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      s        <= '0;
      Cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      carry <= Cin;
      idx   <= '0;
    end else if (state == RUN) begin
      psum  <= psum_next;
      carry <= dig_sum[DIGIT];
      if (last) begin
        s        <= psum_next;
        Cout     <= dig_sum[DIGIT];
        overflow <= msb_carry ^ dig_sum[DIGIT];
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector bench for serial_adder (DIGIT=4 and DIGIT=1)
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;

  logic        busy0, done0, cout0, ovf0;
  logic [31:0] s0;
  logic        busy1, done1, cout1, ovf1;
  logic [31:0] s1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(32), .DIGIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b), .Cin(cin),
    .busy(busy0), .done(done0), .s(s0), .Cout(cout0), .overflow(ovf0)
  );

  serial_adder #(.WIDTH(32), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .Cin(cin),
    .busy(busy1), .done(done1), .s(s1), .Cout(cout1), .overflow(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts an op on the chosen instance; n = digits per op. Checks busy/done over
  // cycles 1..n and the result in cycle n+1. Returns at the negedge of cycle n+1.
  task automatic run_op(input string tag, input bit sel, input int n,
                        input logic [31:0] va, input logic [31:0] vb, input logic vc,
                        input logic [31:0] es, input logic ec, input logic ev);
    int bad;
    @(negedge clk);
    a = va; b = vb; cin = vc;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    bad = 0;
    for (int k = 1; k <= n; k++) begin
      if (sel ? (busy1 !== 1'b1 || done1 !== 1'b0) : (busy0 !== 1'b1 || done0 !== 1'b0)) bad++;
      @(negedge clk);
    end
    check({tag, "_busy_window"}, 32'(bad), 32'd0);
    check({tag, "_done"}, sel ? {31'd0, done1} : {31'd0, done0}, 32'd1);
    check({tag, "_busy_off"}, sel ? {31'd0, busy1} : {31'd0, busy0}, 32'd0);
    check({tag, "_s"}, sel ? s1 : s0, es);
    check({tag, "_cout"}, sel ? {31'd0, cout1} : {31'd0, cout0}, {31'd0, ec});
    check({tag, "_ovf"}, sel ? {31'd0, ovf1} : {31'd0, ovf0}, {31'd0, ev});
  endtask

  initial begin
    int bad;
    #1;
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_s", s0, 32'd0);
    check("rst_cout_ovf", {30'd0, cout0, ovf0}, 32'd0);
    check("rst_dut1", {s1[31:0] | {28'd0, busy1, done1, cout1, ovf1}}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("t1", 1'b0, 8, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    @(negedge clk);
    check("t1_idle_done", {31'd0, done0}, 32'd0);
    check("t1_hold_s", s0, 32'h80000000);
    run_op("t2", 1'b0, 8, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("t3a", 1'b0, 8, 32'd5, 32'd7, 1'b1, 32'h0000000D, 1'b0, 1'b0);
    run_op("t3b", 1'b0, 8, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);

    // t4: start ignored while busy, then back-to-back start in the DONE cycle
    @(negedge clk);
    a = 32'd1; b = 32'd1; cin = 1'b0; start0 = 1'b1;
    @(negedge clk);                 // cycle 1
    start0 = 1'b0;
    repeat (2) @(negedge clk);      // cycle 3
    a = 32'd9; b = 32'd9; start0 = 1'b1;
    @(negedge clk);                 // cycle 4
    start0 = 1'b0;
    check("t4_busy_c4", {31'd0, busy0}, 32'd1);
    repeat (5) @(negedge clk);      // cycle 9
    check("t4_done_c9", {31'd0, done0}, 32'd1);
    check("t4_s_c9", s0, 32'd2);
    a = 32'd3; b = 32'd4; start0 = 1'b1;
    #1;
    check("t4_done_with_start", {31'd0, done0}, 32'd1);
    @(negedge clk);                 // cycle 10
    start0 = 1'b0;
    check("t4_busy_c10", {30'd0, busy0, done0}, 32'd2);
    check("t4_s_held", s0, 32'd2);
    repeat (8) @(negedge clk);      // cycle 18
    check("t4_done_c18", {31'd0, done0}, 32'd1);
    check("t4_s_c18", s0, 32'd7);

    // t5: asynchronous reset in cycle 4 aborts the op
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; start0 = 1'b1;
    @(negedge clk);                 // cycle 1
    start0 = 1'b0;
    repeat (3) @(negedge clk);      // cycle 4
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, busy0}, 32'd0);
    check("t5_rst_s", s0, 32'd0);
    check("t5_rst_flags", {30'd0, cout0, ovf0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (done0 !== 1'b0 || busy0 !== 1'b0) bad++;
      @(negedge clk);
    end
    check("t5_no_done", 32'(bad), 32'd0);
    run_op("t5r", 1'b0, 8, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

    // t6: DIGIT=1 instance, 32 RUN cycles, done in cycle 33
    run_op("t6", 1'b1, 32, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 1'b0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
